// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, default NOP word, PC increment.
package fetch_unit_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StDiscard = 1'b1
  } state_e;

  localparam logic [31:0] NopInstrDefault = 32'h0000_0000;
  localparam int unsigned PcInc           = 4;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register for a fetched {instr, pc_plus4, err} triple.
// Priority: clear > load > consume.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NopInstrDefault)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             consume,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_instr,
  input  logic [WIDTH-1:0] load_pc_plus4,
  input  logic             load_err,
  output logic             valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             err
);

  logic             valid_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_plus4_q;
  logic             err_q;

  // Entry update; pc_plus4 keeps its last value when the entry is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      err_q      <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (load) begin
      valid_q    <= 1'b1;
      instr_q    <= load_instr;
      pc_plus4_q <= load_pc_plus4;
      err_q      <= load_err;
    end else if (consume) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  // Present NOP whenever the entry is empty.
  always_comb begin
    valid    = valid_q;
    instr    = valid_q ? instr_q : NOP_INSTR;
    pc_plus4 = pc_plus4_q;
    err      = err_q;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack handshake and feeds IF/ID
// through a one-entry buffer. Optional misaligned-redirect trap: FETCH_ALIGN_CHK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NopInstrDefault)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_plus4_out,
  output logic             instr_valid,
  output logic             bubble_out,
  output logic             addr_err
);

  localparam logic [WIDTH-1:0] Inc       = WIDTH'(PcInc);
  localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);

  state_e           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] target;

  logic             buf_valid;
  logic             buf_err;
  logic             consume;
  logic             ack;
  logic             misaligned;
  logic [WIDTH-1:0] aligned_pc;
  logic [WIDTH-1:0] new_pc;
  logic             buf_load;
  logic             buf_clear;
  logic [WIDTH-1:0] load_instr;
  logic [WIDTH-1:0] load_pc_plus4;

  // Redirect target decode; a trapped misaligned redirect resumes fetch at the next word.
  always_comb begin
`ifdef FETCH_ALIGN_CHK_EN
    misaligned = |redirect_pc[1:0];
`else
    misaligned = 1'b0;
`endif
    aligned_pc = redirect_pc & AlignMask;
    new_pc     = misaligned ? aligned_pc + Inc : aligned_pc;
  end

  // Request generation and buffer control.
  always_comb begin
    consume  = buf_valid & ~stall_in;
    imem_req = ~reset & ((state == StDiscard) | ~buf_valid | consume);
    // In DISCARD pc is never updated, so it is the held address of the abandoned request.
    imem_addr = pc;
    ack       = imem_ack & imem_req;
    // A trapped redirect loads an error entry instead of clearing the buffer.
    buf_clear     = redirect & ~misaligned;
    buf_load      = redirect ? misaligned : ((state == StRun) & ack);
    load_instr    = misaligned ? NOP_INSTR : imem_rdata;
    load_pc_plus4 = misaligned ? redirect_pc + Inc : pc + Inc;
  end

  // Fetch FSM and PC: redirect beats ack; an unacked request is drained in DISCARD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StRun;
      pc     <= RESET_PC;
      target <= RESET_PC;
    end else begin
      unique case (state)
        StRun: begin
          if (redirect) begin
            if (imem_req && !ack) begin
              target <= new_pc;
              state  <= StDiscard;
            end else begin
              pc <= new_pc;
            end
          end else if (ack) begin
            pc <= pc + Inc;
          end
        end
        StDiscard: begin
          if (redirect) begin
            if (ack) begin
              pc    <= new_pc;
              state <= StRun;
            end else begin
              target <= new_pc;
            end
          end else if (ack) begin
            pc    <= target;
            state <= StRun;
          end
        end
        default: state <= StRun;
      endcase
    end
  end

  fetch_buffer #(
    .WIDTH     (WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_buffer (
    .clk           (clk),
    .reset         (reset),
    .load          (buf_load),
    .consume       (consume),
    .clear         (buf_clear),
    .load_instr    (load_instr),
    .load_pc_plus4 (load_pc_plus4),
    .load_err      (misaligned),
    .valid         (buf_valid),
    .instr         (instr_out),
    .pc_plus4      (pc_plus4_out),
    .err           (buf_err)
  );

  // The error flag is cleared together with its entry, so it never outlives valid.
  always_comb begin
    instr_valid = buf_valid;
    bubble_out  = ~buf_valid;
    addr_err    = buf_err;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/ack/redirect traffic,
// checked against an in-order delivery model of the fetched instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic        instr_valid;
  logic        bubble_out;
  logic        addr_err;
  logic        ack_go;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] exp_addr;
  logic        exp_err;
  logic [31:0] err_pc4;
  logic        pend;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  assign imem_ack   = imem_req & ack_go;
  assign imem_rdata = memf(imem_addr);

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall_in     (stall_in),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_plus4_out (pc_plus4_out),
    .instr_valid  (instr_valid),
    .bubble_out   (bubble_out),
    .addr_err     (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_addr = 32'h0;
    exp_err  = 1'b0;
    err_pc4  = 32'h0;
    pend     = 1'b0;
    pend_addr = 32'h0;
  endtask

  // Move to 2 time units before the next rising edge, check invariants, advance the model.
  task automatic pre();
    #7;
    chk("bubble_inv", {31'b0, bubble_out}, {31'b0, ~instr_valid});
    if (!instr_valid) chk("nop_when_empty", instr_out, Nop);
    if (pend) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, pend_addr);
    end
    if (instr_valid && stall_in && !addr_err) chk("no_overflow", {31'b0, imem_req}, 32'd0);
    if (instr_valid && !stall_in) begin
      if (exp_err) begin
        chk("err_instr", instr_out, Nop);
        chk("err_pc4", pc_plus4_out, err_pc4);
        chk("err_flag", {31'b0, addr_err}, 32'd1);
        exp_err = 1'b0;
      end else begin
        chk("deliver_instr", instr_out, memf(exp_addr));
        chk("deliver_pc4", pc_plus4_out, exp_addr + 32'd4);
        chk("deliver_noerr", {31'b0, addr_err}, 32'd0);
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (redirect) begin
`ifdef FETCH_ALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        exp_err  = 1'b1;
        err_pc4  = redirect_pc + 32'd4;
        exp_addr = (redirect_pc & 32'hFFFF_FFFC) + 32'd4;
      end else begin
        exp_err  = 1'b0;
        exp_addr = redirect_pc;
      end
`else
      exp_err  = 1'b0;
      exp_addr = redirect_pc & 32'hFFFF_FFFC;
`endif
    end
    pend      = imem_req & ~ack_go;
    pend_addr = imem_addr;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    pre();
    post();
  endtask

  initial begin
    reset       = 1'b1;
    stall_in    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ack_go      = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, Nop);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    chk("rst_err", {31'b0, addr_err}, 32'd0);
    reset = 1'b0;

    // Back-to-back fetch with combinational ack
    for (int i = 0; i < 4; i++) begin
      pre();
      chk("seq_req", {31'b0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * i));
      if (i > 0) begin
        chk("seq_valid", {31'b0, instr_valid}, 32'd1);
        chk("seq_pc4", pc_plus4_out, 32'(4 * i));
      end
      post();
    end

    // Ack delayed three cycles at 0x10
    ack_go = 1'b0;
    for (int i = 4; i < 7; i++) begin
      pre();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h10);
      if (i > 4) chk("wait_bubble", {31'b0, bubble_out}, 32'd1);
      post();
    end
    ack_go = 1'b1;
    pre();
    chk("ack_addr", imem_addr, 32'h10);
    chk("ack_bubble", {31'b0, bubble_out}, 32'd1);
    post();

    // Four stall cycles with a full buffer
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pre();
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc4", pc_plus4_out, 32'h14);
      chk("stall_instr", instr_out, memf(32'h10));
      post();
    end
    stall_in = 1'b0;
    pre();
    chk("resume_addr", imem_addr, 32'h14);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    post();
    pre();
    chk("resume_pc4", pc_plus4_out, 32'h18);
    post();
    cyc();

    // Redirect while 0x20 is outstanding, then a second redirect before ack
    ack_go = 1'b0;
    pre();
    chk("pend_addr20", imem_addr, 32'h20);
    post();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    pre();
    chk("disc_req", {31'b0, imem_req}, 32'd1);
    chk("disc_addr", imem_addr, 32'h20);
    chk("disc_valid", {31'b0, instr_valid}, 32'd0);
    post();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    pre();
    chk("disc_addr2", imem_addr, 32'h20);
    post();
    redirect = 1'b0;
    ack_go   = 1'b1;
    pre();
    chk("disc_ack_addr", imem_addr, 32'h20);
    post();
    pre();
    chk("after_disc_addr", imem_addr, 32'h200);
    chk("after_disc_valid", {31'b0, instr_valid}, 32'd0);
    post();
    pre();
    chk("after_disc_pc4", pc_plus4_out, 32'h204);
    post();

    // Redirect coincident with ack
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    pre();
    chk("coinc_req", {31'b0, imem_req}, 32'd1);
    post();
    redirect = 1'b0;
    pre();
    chk("coinc_valid", {31'b0, instr_valid}, 32'd0);
    chk("coinc_addr", imem_addr, 32'h40);
    post();
    pre();
    chk("coinc_pc4", pc_plus4_out, 32'h44);
    post();

    // Misaligned redirect
    redirect    = 1'b1;
    redirect_pc = 32'h42;
    cyc();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    stall_in = 1'b1;
    pre();
    chk("mis_req", {31'b0, imem_req}, 32'd0);
    chk("mis_err", {31'b0, addr_err}, 32'd1);
    chk("mis_instr", instr_out, Nop);
    chk("mis_pc4", pc_plus4_out, 32'h46);
    post();
    stall_in = 1'b0;
    pre();
    chk("mis_next_addr", imem_addr, 32'h44);
    post();
    pre();
    chk("mis_err_clr", {31'b0, addr_err}, 32'd0);
    post();
`else
    pre();
    chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_err", {31'b0, addr_err}, 32'd0);
    post();
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      stall_in = ($urandom_range(0, 9) < 3);
      ack_go   = ($urandom_range(0, 9) < 6);
      redirect = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc = 32'hFFFF_FFF8;
        1:       redirect_pc = $urandom;
        default: redirect_pc = $urandom & 32'h0000_FFFC;
      endcase
      cyc();
    end

    // Reset while a request is outstanding
    stall_in = 1'b0;
    redirect = 1'b0;
    ack_go   = 1'b0;
    cyc();
    cyc();
    pre();
    chk("prerst_req", {31'b0, imem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    post();
    reset  = 1'b0;
    ack_go = 1'b1;
    model_reset();
    pre();
    chk("postrst_addr", imem_addr, 32'h0);
    chk("postrst_req", {31'b0, imem_req}, 32'd1);
    post();
    pre();
    chk("postrst_pc4", pc_plus4_out, 32'h4);
    post();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
